// File: rtl/lap_timer_if.sv
// Lap FIFO read port of the lap timer: the reader pops with lap_rd and sees the
// head entry, the non-empty flag and the sticky overflow flag.
interface lap_timer_if;
    logic        lap_rd;
    logic [15:0] lap_data;
    logic        lap_valid;
    logic        lap_ovf;

    modport master (output lap_rd, input lap_data, lap_valid, lap_ovf);
    modport slave  (input lap_rd, output lap_data, lap_valid, lap_ovf);
endinterface

// File: rtl/lap_timer.sv
// BCD stopwatch / countdown timer (M:SS.t) with a lap-capture FIFO, a frozen
// lap display and a flashing blank indication once a run completes.
module lap_timer #(
    parameter int TICK_DIV    = 10_000_000,
    parameter int MAX_MIN     = 9,
    parameter int LAP_DEPTH   = 4,
    parameter int FLASH_TICKS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Clear,
    input  logic       Countdown,
    input  logic       Lap,
    output logic [3:0] disp_Minutes,
    output logic [3:0] disp_Tens_Seconds,
    output logic [3:0] disp_Ones_Seconds,
    output logic [3:0] disp_Tenths_Seconds,
    output logic       running,
    output logic       done,
    output logic       blank,
    lap_timer_if.slave lap
);

    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW  = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam int AW  = $clog2(LAP_DEPTH);
    localparam int AW1 = AW + 1;

    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0]  FLASH_LAST = FW'(FLASH_TICKS - 1);
    localparam logic [AW:0]    FIFO_FULL  = AW1'(LAP_DEPTH);
    localparam logic [15:0]    T_FULL     = {4'(MAX_MIN), 4'd5, 4'd9, 4'd9};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [15:0]   time_q, time_d;
    logic [15:0]   disp_q, disp_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [FW-1:0] flash_q, flash_d;
    logic          dir_q, dir_d;
    logic          frozen_q, frozen_d;
    logic          blank_q, blank_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    prev_q, prev_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [15:0]   mem_q [LAP_DEPTH];

    logic start_e, stop_e, clear_e, lap_e;
    logic tick, push, pop, flush, full, wr_en;

    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [3:0] m, te, on, tn;
        {m, te, on, tn} = t;
        if (tn != 4'd9) begin
            tn = tn + 4'd1;
        end else begin
            tn = 4'd0;
            if (on != 4'd9) begin
                on = on + 4'd1;
            end else begin
                on = 4'd0;
                if (te != 4'd5) begin
                    te = te + 4'd1;
                end else begin
                    te = 4'd0;
                    m  = m + 4'd1;
                end
            end
        end
        return {m, te, on, tn};
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m, te, on, tn;
        {m, te, on, tn} = t;
        if (tn != 4'd0) begin
            tn = tn - 4'd1;
        end else begin
            tn = 4'd9;
            if (on != 4'd0) begin
                on = on - 4'd1;
            end else begin
                on = 4'd9;
                if (te != 4'd0) begin
                    te = te - 4'd1;
                end else begin
                    te = 4'd5;
                    m  = m - 4'd1;
                end
            end
        end
        return {m, te, on, tn};
    endfunction

    always_comb begin
        start_e  = Start & ~prev_q[3];
        stop_e   = Stop  & ~prev_q[2];
        clear_e  = Clear & ~prev_q[1];
        lap_e    = Lap   & ~prev_q[0];
        tick     = ((state_q == S_RUN) || (state_q == S_DONE)) && (presc_q == PRESC_LAST);

        state_d  = state_q;
        time_d   = time_q;
        disp_d   = disp_q;
        presc_d  = presc_q;
        flash_d  = flash_q;
        dir_d    = dir_q;
        frozen_d = frozen_q;
        blank_d  = blank_q;
        ovf_d    = ovf_q;
        prev_d   = {Start, Stop, Clear, Lap};
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        push     = 1'b0;
        flush    = 1'b0;

        if ((state_q == S_RUN) || (state_q == S_DONE)) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        // Only the highest-priority command edge present acts this cycle.
        if (clear_e) begin
            state_d  = S_IDLE;
            time_d   = 16'd0;
            presc_d  = '0;
            flush    = 1'b1;
            ovf_d    = 1'b0;
            frozen_d = 1'b0;
        end else if (stop_e) begin
            if (state_q == S_RUN) state_d = S_PAUSE;
        end else if (start_e) begin
            if (state_q != S_RUN) begin
                state_d  = S_RUN;
                presc_d  = '0;
                dir_d    = Countdown;
                frozen_d = 1'b0;
                if (Countdown && (state_q != S_PAUSE)) time_d = T_FULL;
            end
        end else if (lap_e && !dir_q && ((state_q == S_RUN) || (state_q == S_PAUSE))) begin
            push     = 1'b1;
            frozen_d = 1'b1;
        end

        // A tick is lost if a command takes the timer out of RUN on the same edge.
        if (tick && (state_q == S_RUN) && (state_d == S_RUN)) begin
            if (!dir_q) begin
                if (time_q == T_FULL) begin
                    time_d  = 16'd0;
                    state_d = S_DONE;
                end else begin
                    time_d = bcd_inc(time_q);
                end
            end else if ((time_q[15:4] == 12'd0) && (time_q[3:0] <= 4'd1)) begin
                time_d  = 16'd0;
                state_d = S_DONE;
            end else begin
                time_d = bcd_dec(time_q);
            end
        end

        if ((state_d != S_DONE) || (state_q != S_DONE)) begin
            blank_d = 1'b0;
            flash_d = '0;
        end else if (tick) begin
            if (flash_q == FLASH_LAST) begin
                flash_d = '0;
                blank_d = ~blank_q;
            end else begin
                flash_d = flash_q + 1'b1;
            end
        end

        if (push || !frozen_d) disp_d = time_q;

        pop   = lap.lap_rd && (cnt_q != '0) && !flush;
        full  = (cnt_q == FIFO_FULL);
        wr_en = push && (!full || pop);
        if (flush) begin
            cnt_d = '0;
            wr_d  = '0;
            rd_d  = '0;
        end else begin
            if (wr_en) wr_d = wr_q + 1'b1;
            if (pop)   rd_d = rd_q + 1'b1;
            if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
            else if (pop && !wr_en) cnt_d = cnt_q - 1'b1;
            if (push && !wr_en)     ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            time_q   <= 16'd0;
            disp_q   <= 16'd0;
            presc_q  <= '0;
            flash_q  <= '0;
            dir_q    <= 1'b0;
            frozen_q <= 1'b0;
            blank_q  <= 1'b0;
            ovf_q    <= 1'b0;
            prev_q   <= 4'd0;
            cnt_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            disp_q   <= disp_d;
            presc_q  <= presc_d;
            flash_q  <= flash_d;
            dir_q    <= dir_d;
            frozen_q <= frozen_d;
            blank_q  <= blank_d;
            ovf_q    <= ovf_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem_q[wr_q] <= time_q;
    end

    assign {disp_Minutes, disp_Tens_Seconds, disp_Ones_Seconds, disp_Tenths_Seconds} = disp_q;
    assign running       = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign blank         = blank_q;
    assign lap.lap_valid = (cnt_q != '0);
    assign lap.lap_ovf   = ovf_q;
    assign lap.lap_data  = (cnt_q != '0) ? mem_q[rd_q] : 16'd0;

endmodule

// File: doc/lap_timer.md
LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10_000_000: clk cycles per tenth-second tick, minimum 1.
REQ-002 SHALL have parameter MAX_MIN, default 9: top minutes value, range 1..9; full scale is MAX_MIN:59.9.
REQ-003 SHALL have parameter LAP_DEPTH, default 4: lap FIFO entries, power of two, 2..16.
REQ-004 SHALL have parameter FLASH_TICKS, default 5: tenth-ticks per blank toggle in DONE.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have ports Start, Stop, Clear, Countdown, Lap, input, 1 each: synchronous command levels; Countdown is a mode level.
REQ-008 SHALL have port lap_rd, input, 1: FIFO pop strobe.
REQ-009 SHALL have ports disp_Minutes, disp_Tens_Seconds, disp_Ones_Seconds, disp_Tenths_Seconds, output, 4 each: displayed BCD time.
REQ-010 SHALL have port lap_data, output, 16: FIFO head as {min, tens, ones, tenths}.
REQ-011 SHALL have ports lap_valid (FIFO non-empty), lap_ovf (sticky drop flag), running, done, blank, output, 1 each.

Function
REQ-012 Start, Stop, Clear and Lap SHALL be rising-edge detected (1 now, 0 previous cycle), acting at that same clk edge; held levels SHALL NOT re-trigger.
REQ-013 Command priority SHALL be reset > Clear > Stop > Start > Lap.
REQ-014 FSM states SHALL be IDLE, RUN, PAUSE, DONE.
REQ-015 IDLE + Start: Countdown=0 -> RUN, time unchanged; Countdown=1 -> time loads MAX_MIN:59.9, then RUN.
REQ-016 PAUSE + Start -> RUN, time unchanged and no reload; RUN + Stop -> PAUSE; DONE + Start SHALL behave as IDLE + Start.
REQ-017 Clear, in any state -> IDLE, time 0:00.0, prescaler 0, FIFO emptied, lap_ovf 0, display unfrozen.
REQ-018 Countdown SHALL be sampled only on a Start edge and latched as the run direction; later changes SHALL have no effect until the next Start edge.
REQ-019 Prescaler SHALL count 0..TICK_DIV-1 in RUN and DONE, hold in IDLE/PAUSE, and zero on entering RUN; a tick occurs on the cycle it equals TICK_DIV-1.
REQ-020 Up-count tick: BCD increment with carries tenths 9->0, ones 9->0, tens 5->0 into minutes.
REQ-021 Up-count tick at MAX_MIN:59.9: time -> 0:00.0, state -> DONE.
REQ-022 Down-count tick: BCD decrement with borrows tenths 0->9, ones 0->9, tens 0->5.
REQ-023 Down-count tick at 0:00.1 -> 0:00.0, state -> DONE on the same edge.
REQ-024 running SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-025 blank SHALL be 0 outside DONE; in DONE it SHALL toggle every FLASH_TICKS ticks, starting at 0 on entry.
REQ-026 Lap edge in RUN or PAUSE, up-count direction: SHALL push current time into the FIFO and freeze the display at that value.
REQ-027 Next Lap edge while frozen: SHALL push and refreeze at the new value.
REQ-028 Start edge from PAUSE: SHALL unfreeze the display.
REQ-029 Lap edge in down-count direction, IDLE or DONE: ignored.
REQ-030 Display SHALL follow the time registers one cycle late (registered) when not frozen.
REQ-031 FIFO full + push: entry dropped, contents unchanged, lap_ovf -> 1 until Clear/reset.
REQ-032 lap_rd with lap_valid=1 SHALL pop; lap_rd with FIFO empty SHALL be ignored.
REQ-033 Push and pop on the same cycle SHALL both occur, occupancy unchanged, including when full.
REQ-034 lap_data SHALL show the head entry and be 0 when empty.

Reset
REQ-035 reset SHALL force, at the next clk edge: state IDLE, time 0:00.0, prescaler 0, direction up, FIFO empty, edge-detect history 0, all outputs 0.
REQ-036 reset mid-RUN or in DONE SHALL take effect the same edge, overriding simultaneous commands.

Verification (TICK_DIV=2, LAP_DEPTH=4, FLASH_TICKS=5)
REQ-037 Up-count: Start pulse, 20 cycles -> disp 0:01.0, running=1; Stop -> held across 10 cycles.
REQ-038 Wrap: preload 9:59.8 via run, 2 ticks -> 0:00.0, done=1; blank toggles after 10 cycles.
REQ-039 Down-count: Countdown=1, Start -> 9:59.9; after 1 tick 9:59.8; Countdown -> 0 mid-run, still decrements.
REQ-040 Laps: 5 Lap edges while running -> lap_ovf=1, 4 entries; pop order matches first 4 captures; fifth pop -> lap_valid=0.
REQ-041 Start+Stop+Lap same cycle in RUN -> PAUSE, no push; Clear+Start -> IDLE 0:00.0.
REQ-042 reset asserted during DONE with blank=1 -> next edge all outputs 0, IDLE.
